audio_min_max_stream: RTL and testbench
=======================================

# audio_min_max_stream

Streaming, parametrised successor to the single-channel min/max block. It consumes a frame of interleaved multi-channel signed audio samples over a valid/ready handshake and computes per-channel signed minimum, maximum and peak-to-peak amplitude. Results are latched with a held done flag. It sits between the audio sample source (file reader / I2S deserialiser) and the level-analysis stage.

## Interface
- `DATA_W`, 32, sample width in bits, two's complement.
- `N_SAMPLES`, 100, samples per channel per frame; must be ≥1.
- `CHANNELS`, 2, interleaved channel count; must be ≥1.
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  frame start request; sampled only in IDLE or DONE.
- `in_valid`  in  1  `in_data` holds a valid sample.
- `in_data`  in  DATA_W  signed sample. Channel order is 0,1,…,CHANNELS-1, then repeats.
- `in_ready`  out  1  block accepts a sample this cycle; registered.
- `busy`  out  1  high in RUN.
- `done`  out  1  results valid; held until next accepted `start` or reset.
- `out_max`  out  CHANNELS*DATA_W  per-channel signed max; channel c at `[c*DATA_W +: DATA_W]`.
- `out_min`  out  CHANNELS*DATA_W  per-channel signed min; same packing.
- `out_p2p`  out  CHANNELS*(DATA_W+1)  per-channel unsigned max−min; channel c at `[c*(DATA_W+1) +: DATA_W+1]`.

## Operation
- **States:** IDLE, RUN, DONE.
- **IDLE:**
  - `in_ready`=0, `busy`=0, `done`=0.
  - `start`=1 → RUN.
- **RUN:**
  - `in_ready`=1, `busy`=1.
  - A beat is accepted when `in_valid && in_ready`.
  - `start` is ignored.
- **DONE:**
  - `done`=1; results held.
  - `start`=1 → RUN and clears `done` on the same edge.
- **Entering RUN:**
  - Channel index `ch` ← 0 and beat counter ← 0.
  - Per-channel "first" flags set; running min/max are not cleared to 0.
- **Accepted beat for channel `ch`:**
  - If first[ch]: run_min[ch] = run_max[ch] = in_data, and first[ch] is cleared.
  - Otherwise: run_min[ch] updates if in_data < run_min[ch], and run_max[ch] updates if in_data > run_max[ch]. Both comparisons are evaluated independently (not else-if) and are signed.
  - `ch` wraps CHANNELS-1 → 0.
- **Beat counter:**
  - Counts 0 … N_SAMPLES*CHANNELS−1, width $clog2(N_SAMPLES*CHANNELS).
  - The last beat's value participates in the result.
- **On the last accepted beat:**
  - Output registers load the final min/max, including the last sample, via bypass of the running regs.
  - `out_p2p` = max − min, computed in DATA_W+1 bits; it never overflows.
  - State → DONE.
- **Output registers:**
  - Change only on last-beat completion or reset.
  - Previous results stay visible during a new RUN until it completes; `done`=0 marks them stale.
- **Gaps:** `in_valid` gaps stall without side effects; no timeout.
- **Reset (any state, incl. mid-frame):**
  - State IDLE; all outputs 0.
  - Counters, `ch` and running regs cleared; first flags set.
  - A partial frame is discarded.

## Timing
- `in_ready` rises the cycle after the edge that samples `start` in IDLE/DONE.
- Throughput is 1 sample/cycle with `in_valid` held high. Minimum frame is N_SAMPLES*CHANNELS cycles in RUN.
- Last beat accepted at edge k:
  - `done`, `out_*` valid and `in_ready`=0 from edge k (visible in cycle k+1).
  - A beat presented in cycle k+1 is not accepted.
- `start` high in DONE at edge j: `done`=0 and `in_ready`=1 after edge j. Back-to-back frames lose one cycle.
- `start` held high continuously restarts a frame each time DONE is reached.
- Reset deassertion is synchronised externally; the first active edge after deassertion sees IDLE.

## Test plan
- **Basic frame:** CHANNELS=2, N_SAMPLES=4, DATA_W=32.
  - Stimulus: interleaved ch0 {5,−3,7,2}, ch1 {−10,−20,−15,−11}.
  - Required: ch0 max 7, min −3, p2p 10; ch1 max −10, min −20, p2p 10. `done`=1 one cycle after the 8th beat.
- **All-negative / first-sample init:** CHANNELS=1, N_SAMPLES=3, samples {−5,−9,−7}.
  - Required: max −5 (not 0), min −9, p2p 4.
- **Extremes and single sample:**
  - DATA_W=8, CHANNELS=1, N_SAMPLES=2, samples {−128,127}: max 127, min −128, p2p 255, no overflow.
  - N_SAMPLES=1, sample 42: max=min=42, p2p 0.
- **Handshake stalls:** default params, `in_valid` toggling pseudo-randomly.
  - Required: results identical to the no-stall run.
  - Required: exactly 200 beats consumed; `in_ready`=0 in IDLE/DONE; `start` mid-RUN ignored.
- **Back-to-back frames:**
  - Stimulus: assert `start` in DONE; second frame all zeros.
  - Required: `done` drops for exactly the second frame; previous results held until its last beat, then all outputs 0.
- **Mid-frame reset:**
  - Stimulus: assert `reset`=0 after 37 beats (async, between edges).
  - Required: outputs 0 immediately and state IDLE.
  - Required: a following full frame yields correct results with no residue from the aborted frame.

Source files
------------

// File: rtl/audio_min_max_stream_if.sv
// rtl/audio_min_max_stream_if.sv - sample stream handshake between source and min/max block
interface audio_min_max_stream_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/audio_min_max_stream.sv
// rtl/audio_min_max_stream.sv - per-channel signed min/max/peak-to-peak over an interleaved frame
module audio_min_max_stream #(
    parameter int DATA_W    = 32,
    parameter int N_SAMPLES = 100,
    parameter int CHANNELS  = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    audio_min_max_stream_if.slave          src,
    output logic                           busy,
    output logic                           done,
    output logic [CHANNELS*DATA_W-1:0]     out_max,
    output logic [CHANNELS*DATA_W-1:0]     out_min,
    output logic [CHANNELS*(DATA_W+1)-1:0] out_p2p
);
    localparam int TOTAL = N_SAMPLES * CHANNELS;
    localparam int CNT_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state, next_state;

    logic [CNT_W-1:0]         cnt;
    logic [CH_W-1:0]          ch;
    logic [CHANNELS-1:0]      first;
    logic signed [DATA_W-1:0] run_min [CHANNELS];
    logic signed [DATA_W-1:0] run_max [CHANNELS];

    logic signed [DATA_W-1:0] sample;
    logic signed [DATA_W-1:0] new_min;
    logic signed [DATA_W-1:0] new_max;
    logic signed [DATA_W-1:0] fin_min [CHANNELS];
    logic signed [DATA_W-1:0] fin_max [CHANNELS];
    logic [DATA_W:0]          fin_p2p [CHANNELS];

    logic beat;
    logic last_beat;
    logic launch;

    assign sample    = $signed(src.in_data);
    assign beat      = src.in_valid && src.in_ready;
    assign last_beat = beat && (cnt == CNT_W'(TOTAL - 1));
    assign launch    = start && ((state == IDLE) || (state == DONE));

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: start is only honoured outside RUN
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start)     next_state = RUN;
            RUN:     if (last_beat) next_state = DONE;
            DONE:    if (start)     next_state = RUN;
            default:                next_state = IDLE;
        endcase
    end

    // Status outputs decoded from the state
    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // Ready is registered and tracks the state we are about to be in
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            src.in_ready <= 1'b0;
        end else begin
            src.in_ready <= (next_state == RUN);
        end
    end

    // Updated extremes for the channel of the current beat; first sample seeds both
    always_comb begin
        new_min = run_min[ch];
        new_max = run_max[ch];
        if (first[ch]) begin
            new_min = sample;
            new_max = sample;
        end else begin
            if (sample < run_min[ch]) new_min = sample;
            if (sample > run_max[ch]) new_max = sample;
        end
    end

    // Frame bookkeeping and running extremes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            ch    <= '0;
            first <= '1;
            for (int c = 0; c < CHANNELS; c++) begin
                run_min[c] <= '0;
                run_max[c] <= '0;
            end
        end else if (launch) begin
            cnt   <= '0;
            ch    <= '0;
            first <= '1;
        end else if (beat) begin
            run_min[ch] <= new_min;
            run_max[ch] <= new_max;
            first[ch]   <= 1'b0;
            ch          <= (ch == CH_W'(CHANNELS - 1)) ? '0 : ch + 1'b1;
            cnt         <= last_beat ? '0 : cnt + 1'b1;
        end
    end

    // Final results with the in-flight beat bypassed into its channel
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            fin_min[c] = (CH_W'(c) == ch) ? new_min : run_min[c];
            fin_max[c] = (CH_W'(c) == ch) ? new_max : run_max[c];
            fin_p2p[c] = {fin_max[c][DATA_W-1], fin_max[c]} - {fin_min[c][DATA_W-1], fin_min[c]};
        end
    end

    // Result registers change only when a frame completes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_max <= '0;
            out_min <= '0;
            out_p2p <= '0;
        end else if (last_beat) begin
            for (int c = 0; c < CHANNELS; c++) begin
                out_max[c*DATA_W +: DATA_W]         <= fin_max[c];
                out_min[c*DATA_W +: DATA_W]         <= fin_min[c];
                out_p2p[c*(DATA_W+1) +: DATA_W + 1] <= fin_p2p[c];
            end
        end
    end
endmodule

// File: tb/tb_audio_min_max_stream.sv
// tb/tb_audio_min_max_stream.sv - directed table-driven bench for audio_min_max_stream
`timescale 1ns/1ps
module tb_audio_min_max_stream;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start [5];
    logic        valid [5];
    logic [31:0] dbus  [5];
    logic        rdy   [5];
    logic        dn    [5];
    logic        bsy   [5];

    logic [63:0] om0, on0; logic [65:0] op0;
    logic [31:0] om1, on1; logic [32:0] op1;
    logic [7:0]  om2, on2; logic [8:0]  op2;
    logic [31:0] om3, on3; logic [32:0] op3;
    logic [63:0] om4, on4; logic [65:0] op4;

    audio_min_max_stream_if #(.DATA_W(32)) if0 ();
    audio_min_max_stream_if #(.DATA_W(32)) if1 ();
    audio_min_max_stream_if #(.DATA_W(8))  if2 ();
    audio_min_max_stream_if #(.DATA_W(32)) if3 ();
    audio_min_max_stream_if #(.DATA_W(32)) if4 ();

    assign if0.in_valid = valid[0]; assign if0.in_data = dbus[0];      assign rdy[0] = if0.in_ready;
    assign if1.in_valid = valid[1]; assign if1.in_data = dbus[1];      assign rdy[1] = if1.in_ready;
    assign if2.in_valid = valid[2]; assign if2.in_data = dbus[2][7:0]; assign rdy[2] = if2.in_ready;
    assign if3.in_valid = valid[3]; assign if3.in_data = dbus[3];      assign rdy[3] = if3.in_ready;
    assign if4.in_valid = valid[4]; assign if4.in_data = dbus[4];      assign rdy[4] = if4.in_ready;

    audio_min_max_stream #(.DATA_W(32), .N_SAMPLES(4), .CHANNELS(2)) dut0 (
        .clk(clk), .reset(rst_n), .start(start[0]), .src(if0), .busy(bsy[0]), .done(dn[0]),
        .out_max(om0), .out_min(on0), .out_p2p(op0));
    audio_min_max_stream #(.DATA_W(32), .N_SAMPLES(3), .CHANNELS(1)) dut1 (
        .clk(clk), .reset(rst_n), .start(start[1]), .src(if1), .busy(bsy[1]), .done(dn[1]),
        .out_max(om1), .out_min(on1), .out_p2p(op1));
    audio_min_max_stream #(.DATA_W(8), .N_SAMPLES(2), .CHANNELS(1)) dut2 (
        .clk(clk), .reset(rst_n), .start(start[2]), .src(if2), .busy(bsy[2]), .done(dn[2]),
        .out_max(om2), .out_min(on2), .out_p2p(op2));
    audio_min_max_stream #(.DATA_W(32), .N_SAMPLES(1), .CHANNELS(1)) dut3 (
        .clk(clk), .reset(rst_n), .start(start[3]), .src(if3), .busy(bsy[3]), .done(dn[3]),
        .out_max(om3), .out_min(on3), .out_p2p(op3));
    audio_min_max_stream #(.DATA_W(32), .N_SAMPLES(100), .CHANNELS(2)) dut4 (
        .clk(clk), .reset(rst_n), .start(start[4]), .src(if4), .busy(bsy[4]), .done(dn[4]),
        .out_max(om4), .out_min(on4), .out_p2p(op4));

    longint gmax [5][2];
    longint gmin [5][2];
    longint gp2p [5][2];

    always_comb begin
        for (int k = 0; k < 5; k++) begin
            for (int c = 0; c < 2; c++) begin
                gmax[k][c] = 0; gmin[k][c] = 0; gp2p[k][c] = 0;
            end
        end
        gmax[0][0] = longint'($signed(om0[31:0]));  gmax[0][1] = longint'($signed(om0[63:32]));
        gmin[0][0] = longint'($signed(on0[31:0]));  gmin[0][1] = longint'($signed(on0[63:32]));
        gp2p[0][0] = longint'(op0[32:0]);           gp2p[0][1] = longint'(op0[65:33]);
        gmax[1][0] = longint'($signed(om1));        gmin[1][0] = longint'($signed(on1));
        gp2p[1][0] = longint'(op1);
        gmax[2][0] = longint'($signed(om2));        gmin[2][0] = longint'($signed(on2));
        gp2p[2][0] = longint'(op2);
        gmax[3][0] = longint'($signed(om3));        gmin[3][0] = longint'($signed(on3));
        gp2p[3][0] = longint'(op3);
        gmax[4][0] = longint'($signed(om4[31:0]));  gmax[4][1] = longint'($signed(om4[63:32]));
        gmin[4][0] = longint'($signed(on4[31:0]));  gmin[4][1] = longint'($signed(on4[63:32]));
        gp2p[4][0] = longint'(op4[32:0]);           gp2p[4][1] = longint'(op4[65:33]);
    end

    int beats4 = 0;
    int bad_ready = 0;
    always @(posedge clk) if (valid[4] && rdy[4]) beats4 <= beats4 + 1;
    always @(negedge clk) if (rst_n && rdy[4] && !bsy[4]) bad_ready <= bad_ready + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(string name, longint got, longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Entered and left at posedge+1; waits until the sample is accepted
    task automatic push(int k, logic [31:0] d, int gaps);
        int t;
        valid[k] = 1'b0;
        for (int g = 0; g < gaps; g++) begin
            @(posedge clk); #1;
        end
        dbus[k]  = d;
        valid[k] = 1'b1;
        t = 0;
        while (t < 20) begin
            @(negedge clk);
            if (rdy[k]) break;
            t++;
        end
        @(posedge clk); #1;
        valid[k] = 1'b0;
        if (t >= 20) begin
            n_tests++;
            n_fail++;
            $display("FAIL push_timeout inst%0d: got no ready expected ready", k);
        end
    endtask

    task automatic pulse_start(int k);
        start[k] = 1'b1;
        @(posedge clk); #1;
        start[k] = 1'b0;
    endtask

    typedef struct {
        int inst;
        int nch;
        int n;
        int s [8];
        int emax [2];
        int emin [2];
        int ep2p [2];
    } vec_t;

    vec_t tv [6];

    int     smp [200];
    longint emax4 [2];
    longint emin4 [2];

    task automatic model4(int neg);
        for (int c = 0; c < 2; c++) begin
            emax4[c] = neg ? -longint'(smp[c]) : longint'(smp[c]);
            emin4[c] = emax4[c];
        end
        for (int i = 0; i < 200; i++) begin
            longint v;
            v = neg ? -longint'(smp[i]) : longint'(smp[i]);
            if (v > emax4[i % 2]) emax4[i % 2] = v;
            if (v < emin4[i % 2]) emin4[i % 2] = v;
        end
    endtask

    task automatic check4(string tag);
        for (int c = 0; c < 2; c++) begin
            check($sformatf("%s ch%0d max", tag, c), gmax[4][c], emax4[c]);
            check($sformatf("%s ch%0d min", tag, c), gmin[4][c], emin4[c]);
            check($sformatf("%s ch%0d p2p", tag, c), gp2p[4][c], emax4[c] - emin4[c]);
        end
    endtask

    initial begin
        int b0;
        for (int k = 0; k < 5; k++) begin
            start[k] = 1'b0; valid[k] = 1'b0; dbus[k] = '0;
        end

        tv[0].inst = 0; tv[0].nch = 2; tv[0].n = 8;
        tv[0].s = '{5, -10, -3, -20, 7, -15, 2, -11};
        tv[0].emax = '{7, -10}; tv[0].emin = '{-3, -20}; tv[0].ep2p = '{10, 10};
        tv[1].inst = 0; tv[1].nch = 2; tv[1].n = 8;
        tv[1].s = '{0, 1, 0, -1, 0, 1, 0, -1};
        tv[1].emax = '{0, 1}; tv[1].emin = '{0, -1}; tv[1].ep2p = '{0, 2};
        tv[2].inst = 1; tv[2].nch = 1; tv[2].n = 3;
        tv[2].s = '{-5, -9, -7, 0, 0, 0, 0, 0};
        tv[2].emax = '{-5, 0}; tv[2].emin = '{-9, 0}; tv[2].ep2p = '{4, 0};
        tv[3].inst = 2; tv[3].nch = 1; tv[3].n = 2;
        tv[3].s = '{-128, 127, 0, 0, 0, 0, 0, 0};
        tv[3].emax = '{127, 0}; tv[3].emin = '{-128, 0}; tv[3].ep2p = '{255, 0};
        tv[4].inst = 2; tv[4].nch = 1; tv[4].n = 2;
        tv[4].s = '{127, -128, 0, 0, 0, 0, 0, 0};
        tv[4].emax = '{127, 0}; tv[4].emin = '{-128, 0}; tv[4].ep2p = '{255, 0};
        tv[5].inst = 3; tv[5].nch = 1; tv[5].n = 1;
        tv[5].s = '{42, 0, 0, 0, 0, 0, 0, 0};
        tv[5].emax = '{42, 0}; tv[5].emin = '{42, 0}; tv[5].ep2p = '{0, 0};

        for (int i = 0; i < 200; i++) smp[i] = int'($urandom_range(0, 2000)) - 1000;
        smp[10] = 32'h7fffffff;
        smp[13] = 32'h80000001;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        check("reset done", longint'(dn[4]), 0);
        check("reset busy", longint'(bsy[4]), 0);
        check("reset ready", longint'(rdy[4]), 0);
        check("reset max4", gmax[4][0], 0);
        check("reset p2p4", gp2p[4][1], 0);

        for (int v = 0; v < 6; v++) begin
            int k;
            k = tv[v].inst;
            pulse_start(k);
            check($sformatf("v%0d ready after start", v), longint'(rdy[k]), 1);
            check($sformatf("v%0d done after start", v), longint'(dn[k]), 0);
            for (int i = 0; i < tv[v].n; i++) push(k, tv[v].s[i], 0);
            check($sformatf("v%0d done", v), longint'(dn[k]), 1);
            check($sformatf("v%0d ready after last", v), longint'(rdy[k]), 0);
            for (int c = 0; c < tv[v].nch; c++) begin
                check($sformatf("v%0d ch%0d max", v, c), gmax[k][c], tv[v].emax[c]);
                check($sformatf("v%0d ch%0d min", v, c), gmin[k][c], tv[v].emin[c]);
                check($sformatf("v%0d ch%0d p2p", v, c), gp2p[k][c], tv[v].ep2p[c]);
            end
        end

        model4(0);
        pulse_start(4);
        b0 = beats4;
        for (int i = 0; i < 200; i++) push(4, smp[i], 0);
        check("nostall beats", beats4 - b0, 200);
        check("nostall done", longint'(dn[4]), 1);
        check4("nostall");
        valid[4] = 1'b1;
        @(posedge clk); #1;
        valid[4] = 1'b0;
        check("beat after last ignored", beats4 - b0, 200);

        pulse_start(4);
        b0 = beats4;
        for (int i = 0; i < 200; i++) begin
            if (i == 50) start[4] = 1'b1;
            push(4, smp[i], (($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0));
            start[4] = 1'b0;
        end
        check("stall beats", beats4 - b0, 200);
        check("stall done", longint'(dn[4]), 1);
        check4("stall");

        pulse_start(4);
        check("b2b done drop", longint'(dn[4]), 0);
        check("b2b ready", longint'(rdy[4]), 1);
        for (int i = 0; i < 199; i++) push(4, 32'd0, 0);
        check("b2b done before last", longint'(dn[4]), 0);
        check4("b2b held");
        push(4, 32'd0, 0);
        check("b2b done", longint'(dn[4]), 1);
        for (int c = 0; c < 2; c++) begin
            check($sformatf("b2b zero max ch%0d", c), gmax[4][c], 0);
            check($sformatf("b2b zero min ch%0d", c), gmin[4][c], 0);
            check($sformatf("b2b zero p2p ch%0d", c), gp2p[4][c], 0);
        end

        pulse_start(4);
        for (int i = 0; i < 37; i++) push(4, 32'h7ffffff0 - i, 0);
        #1 rst_n = 1'b0;
        #1;
        check("midreset max", gmax[4][0], 0);
        check("midreset min", gmin[4][1], 0);
        check("midreset p2p", gp2p[4][0], 0);
        check("midreset busy", longint'(bsy[4]), 0);
        check("midreset ready", longint'(rdy[4]), 0);
        #4 rst_n = 1'b1;
        @(posedge clk); #1;
        check("post reset idle", longint'(bsy[4]), 0);
        model4(1);
        pulse_start(4);
        for (int i = 0; i < 200; i++) push(4, -smp[i], 0);
        check("post reset done", longint'(dn[4]), 1);
        check4("post reset");

        check("ready outside run", bad_ready, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
